// File: rtl/gba_wait_ctrl.sv
// Wait-state generator: classifies bus accesses as sequential/non-sequential and stalls the CPU.
// Optional statistics counters are built only when GBA_WAIT_STATS_EN is defined.
module gba_wait_ctrl #(
   parameter int NUM_REGIONS    = 16,
   parameter int REGION_SHIFT   = 24,
   parameter int CNT_W          = 3,
   parameter int SEQ_BOUND_BITS = 17,
   localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req,
   input  logic [31:0]                  addr,
   input  logic [1:0]                   size,
   input  logic                         write,
   input  logic [NUM_REGIONS*CNT_W-1:0] n_wait,
   input  logic [NUM_REGIONS*CNT_W-1:0] s_wait,
   input  logic [NUM_REGIONS-1:0]       ro_mask,
   output logic                         pause,
   output logic                         abort,
   output logic                         seq,
   output logic [RW-1:0]                region,
   output logic [31:0]                  stat_acc,
   output logic [31:0]                  stat_seq,
   output logic [31:0]                  stat_stall
);

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_RESR = 2'd3;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pause_q, pause_d;
   logic              abort_q, abort_d;
   logic              seq_q, seq_d;
   logic [RW-1:0]     region_q, region_d;
   logic              prev_valid_q, prev_valid_d;
   logic [31:0]       prev_addr_q, prev_addr_d;
   logic [1:0]        prev_size_q, prev_size_d;
   logic              prev_write_q, prev_write_d;
   logic [RW-1:0]     prev_region_q, prev_region_d;

   logic              accept;
   logic              acc_seq;
   logic              acc_illegal;
   logic [RW-1:0]     acc_region;
   logic [31:0]       step;
   logic [CNT_W-1:0]  w_sel;

   always_comb begin
      acc_region = addr[REGION_SHIFT +: RW];
      case (size)
         MEM_SIZE_BYTE: step = 32'd1;
         MEM_SIZE_HALF: step = 32'd2;
         default:       step = 32'd4;
      endcase
      // Reserved-size accesses never chain; they abort anyway.
      acc_seq = prev_valid_q && (size != MEM_SIZE_RESR) &&
                (acc_region == prev_region_q) && (write == prev_write_q) &&
                (size == prev_size_q) && (addr == prev_addr_q + step) &&
                (addr[SEQ_BOUND_BITS-1:0] != '0);
      acc_illegal = (size == MEM_SIZE_RESR) || (write && ro_mask[acc_region]);
      if (acc_illegal)
         w_sel = '0;
      else if (acc_seq)
         w_sel = s_wait[int'(acc_region)*CNT_W +: CNT_W];
      else
         w_sel = n_wait[int'(acc_region)*CNT_W +: CNT_W];
      accept = req && !pause_q && (state_q == IDLE);
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pause_d       = pause_q;
      abort_d       = 1'b0;
      seq_d         = seq_q;
      region_d      = region_q;
      prev_valid_d  = prev_valid_q;
      prev_addr_d   = prev_addr_q;
      prev_size_d   = prev_size_q;
      prev_write_d  = prev_write_q;
      prev_region_d = prev_region_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               abort_d       = acc_illegal;
               seq_d         = acc_seq;
               region_d      = acc_region;
               prev_valid_d  = 1'b1;
               prev_addr_d   = addr;
               prev_size_d   = size;
               prev_write_d  = write;
               prev_region_d = acc_region;
               if (w_sel != '0) begin
                  state_d = WAIT;
                  cnt_d   = w_sel;
                  pause_d = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               pause_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            pause_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         pause_q       <= 1'b0;
         abort_q       <= 1'b0;
         seq_q         <= 1'b0;
         region_q      <= '0;
         prev_valid_q  <= 1'b0;
         prev_addr_q   <= '0;
         prev_size_q   <= '0;
         prev_write_q  <= 1'b0;
         prev_region_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pause_q       <= pause_d;
         abort_q       <= abort_d;
         seq_q         <= seq_d;
         region_q      <= region_d;
         prev_valid_q  <= prev_valid_d;
         prev_addr_q   <= prev_addr_d;
         prev_size_q   <= prev_size_d;
         prev_write_q  <= prev_write_d;
         prev_region_q <= prev_region_d;
      end
   end

   assign pause  = pause_q;
   assign abort  = abort_q;
   assign seq    = seq_q;
   assign region = region_q;

`ifdef GBA_WAIT_STATS_EN
   logic [31:0] stat_acc_q, stat_acc_d;
   logic [31:0] stat_seq_q, stat_seq_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // Saturating counters; stall counts each cycle in which pause was presented.
   always_comb begin
      stat_acc_d   = stat_acc_q;
      stat_seq_d   = stat_seq_q;
      stat_stall_d = stat_stall_q;
      if (accept && (stat_acc_q != 32'hFFFF_FFFF))
         stat_acc_d = stat_acc_q + 32'd1;
      if (accept && acc_seq && (stat_seq_q != 32'hFFFF_FFFF))
         stat_seq_d = stat_seq_q + 32'd1;
      if (pause_q && (stat_stall_q != 32'hFFFF_FFFF))
         stat_stall_d = stat_stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_acc_q   <= '0;
         stat_seq_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_acc_q   <= stat_acc_d;
         stat_seq_q   <= stat_seq_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_acc   = stat_acc_q;
   assign stat_seq   = stat_seq_q;
   assign stat_stall = stat_stall_q;
`else
   assign stat_acc   = '0;
   assign stat_seq   = '0;
   assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_gba_wait_ctrl.sv
// Scoreboard bench for gba_wait_ctrl: driver queues expected responses, monitor checks them.
module tb_gba_wait_ctrl;

   localparam int NR = 16;
   localparam int CW = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req = 1'b0;
   logic [31:0]    addr = '0;
   logic [1:0]     size = 2'd2;
   logic           write = 1'b0;
   logic [NR*CW-1:0] n_wait = '0;
   logic [NR*CW-1:0] s_wait = '0;
   logic [NR-1:0]  ro_mask = '0;
   logic           pause, abort, seq;
   logic [3:0]     region;
   logic [31:0]    stat_acc, stat_seq, stat_stall;

   gba_wait_ctrl dut (
      .clk(clk), .rst(rst), .req(req), .addr(addr), .size(size), .write(write),
      .n_wait(n_wait), .s_wait(s_wait), .ro_mask(ro_mask),
      .pause(pause), .abort(abort), .seq(seq), .region(region),
      .stat_acc(stat_acc), .stat_seq(stat_seq), .stat_stall(stat_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      string     name;
      bit        e_seq;
      bit [3:0]  e_reg;
      bit        e_abort;
      int        e_wait;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
      end
   endtask

   task automatic set_n(input int r, input int v);
      n_wait[r*CW +: CW] = CW'(v);
   endtask

   task automatic set_s(input int r, input int v);
      s_wait[r*CW +: CW] = CW'(v);
   endtask

   // Called at posedge+#1; presents one access and returns just after it is accepted.
   task automatic access(input string name, input logic [31:0] a, input logic [1:0] sz,
                         input logic w, input bit e_seq, input bit [3:0] e_reg,
                         input bit e_abort, input int e_wait);
      exp_t e;
      int guard = 0;
      while (pause && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         failures++;
         $display("FAIL %s_idle: pause stuck high, expected low within 50 cycles", name);
      end
      e.name = name; e.e_seq = e_seq; e.e_reg = e_reg; e.e_abort = e_abort; e.e_wait = e_wait;
      exp_q.push_back(e);
      req = 1'b1; addr = a; size = sz; write = w;
      @(posedge clk);
      #1;
      req = 1'b0;
      $display("access %s addr=0x%08h size=%0d write=%0d exp_seq=%0d exp_region=%0d exp_abort=%0d exp_wait=%0d",
               name, a, sz, w, e_seq, e_reg, e_abort, e_wait);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (pause && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
   endtask

   // Monitor: observes acceptance edges, then checks classification and pause length.
   initial begin
      exp_t e;
      int n;
      forever begin
         @(posedge clk);
         if (!rst && req && !pause) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_accept: got acceptance at addr 0x%08h, expected none", addr);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, "_seq"}, 32'(seq), 32'(e.e_seq));
               chk({e.name, "_region"}, 32'(region), 32'(e.e_reg));
               chk({e.name, "_abort"}, 32'(abort), 32'(e.e_abort));
               n = 0;
               while (pause && n < 20) begin
                  n++;
                  @(negedge clk);
               end
               chk({e.name, "_pause_cycles"}, 32'(n), 32'(e.e_wait));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      set_n(8, 4); set_s(8, 1);
      set_n(15, 2);
      ro_mask[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_pause", 32'(pause), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_seq", 32'(seq), 32'd0);
      chk("rst_region", 32'(region), 32'd0);
      chk("rst_stat_acc", stat_acc, 32'd0);

      access("nseq_word", 32'h0800_0000, 2'd2, 1'b0, 1'b0, 4'd8, 1'b0, 4);
      access("seq_word",  32'h0800_0004, 2'd2, 1'b0, 1'b1, 4'd8, 1'b0, 1);
      wait_idle();
      @(posedge clk);
      #1;
`ifdef GBA_WAIT_STATS_EN
      chk("stat_acc", stat_acc, 32'd2);
      chk("stat_seq", stat_seq, 32'd1);
      chk("stat_stall", stat_stall, 32'd5);
`else
      chk("stat_acc_tied", stat_acc, 32'd0);
      chk("stat_seq_tied", stat_seq, 32'd0);
      chk("stat_stall_tied", stat_stall, 32'd0);
`endif
      access("size_change", 32'h0800_0006, 2'd1, 1'b0, 1'b0, 4'd8, 1'b0, 4);
      access("pre_bound",   32'h0801_FFFC, 2'd2, 1'b0, 1'b0, 4'd8, 1'b0, 4);
      access("bound_128k",  32'h0802_0000, 2'd2, 1'b0, 1'b0, 4'd8, 1'b0, 4);
      access("ro_write",    32'h0000_0010, 2'd2, 1'b1, 1'b0, 4'd0, 1'b1, 0);
      access("after_abort", 32'h0000_0014, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0, 0);
      access("seq_zero",    32'h0000_0018, 2'd2, 1'b0, 1'b1, 4'd0, 1'b0, 0);
      access("resr_size",   32'h0200_0000, 2'd3, 1'b0, 1'b0, 4'd2, 1'b1, 0);
      for (int i = 0; i < 4; i++)
         access("zero_wait", 32'h0300_0000 + 32'(4 * i), 2'd2, 1'b0, (i != 0), 4'd3, 1'b0, 0);
      access("rw_write", 32'h0300_0010, 2'd2, 1'b1, 1'b0, 4'd3, 1'b0, 0);

      set_n(8, 5);
      access("in_flight", 32'h0800_0100, 2'd2, 1'b0, 1'b0, 4'd8, 1'b0, 5);
      set_n(8, 1);
      wait_idle();

      set_n(8, 7);
      access("rst_mid_wait", 32'h0800_0200, 2'd2, 1'b0, 1'b0, 4'd8, 1'b0, 3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_pause", 32'(pause), 32'd0);
      chk("midrst_region", 32'(region), 32'd0);
      chk("midrst_stat_acc", stat_acc, 32'd0);
      access("post_rst", 32'h0800_0204, 2'd2, 1'b0, 1'b0, 4'd8, 1'b0, 7);

      access("top_word", 32'hFFFF_FFFC, 2'd2, 1'b0, 1'b0, 4'd15, 1'b0, 2);
      access("wrap_zero", 32'h0000_0000, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0, 0);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
